// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences PC/IR/regfile/ALU/memory strobes,
// absorbs memory wait states, counts retired instructions and halts on faults.
module mips_mc_ctrl #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_rdy,
    output logic             pc_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             iord,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             instr_done,
    output logic [1:0]       halt_code,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] HC_RUN     = 2'b00;
    localparam logic [1:0] HC_ILLEGAL = 2'b01;
    localparam logic [1:0] HC_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        halt_q, halt_d;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wait_inc;
    logic              timeout;

    assign timeout     = (wait_q == WAIT_W'(MAX_WAIT - 1));
    assign state       = state_q;
    assign halt_code   = halt_q;
    assign instret_cnt = cnt_q;

    // State, halt code, wait counter and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            halt_q  <= HC_RUN;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            wait_q  <= wait_inc ? wait_q + WAIT_W'(1) : '0;
            if (instr_done) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state and per-state datapath strobes
    always_comb begin
        state_d    = state_q;
        halt_d     = halt_q;
        wait_inc   = 1'b0;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        pc_src     = 2'b00;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                if (mem_rdy) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                    halt_d  = HC_TIMEOUT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                            funct == FN_OR  || funct == FN_SLT) begin
                            state_d = S_EXEC;
                        end else begin
                            state_d = S_HALT;
                            halt_d  = HC_ILLEGAL;
                        end
                    end
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_HALT;
                        halt_d  = HC_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                if (mem_rdy) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    state_d = S_HALT;
                    halt_d  = HC_TIMEOUT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_MEMWB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                if (mem_rdy) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (timeout) begin
                    state_d = S_HALT;
                    halt_d  = HC_TIMEOUT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we     = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_src     = 2'b01;
                pc_we      = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
                halt_d  = HC_ILLEGAL;
            end
        endcase

        // Reset silences every strobe in the same cycle
        if (rst) begin
            wait_inc   = 1'b0;
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            reg_we     = 1'b0;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            iord       = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = ALU_ADD;
            pc_src     = 2'b00;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: per-cycle expected observations are queued
// with their stimulus, then popped and compared as the cycles are driven.
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode, funct;
    logic        zero, mem_rdy;
    logic        pc_we, ir_we, reg_we, mem_rd, mem_wr, iord, alu_src_a;
    logic [1:0]  alu_src_b, pc_src, halt_code;
    logic [2:0]  alu_op;
    logic        reg_dst, mem_to_reg, instr_done;
    logic [3:0]  state;
    logic [31:0] instret_cnt;

    mips_mc_ctrl #(.CNT_W(32), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_rdy(mem_rdy), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .halt_code(halt_code),
        .state(state), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic        pc_we, ir_we, reg_we, mem_rd, mem_wr, iord, src_a;
        logic [1:0]  src_b;
        logic [2:0]  alu_op;
        logic [1:0]  pc_src;
        logic        reg_dst, mem_to_reg, done;
        logic [1:0]  hc;
        logic [31:0] cnt;
    } obs_t;

    typedef struct packed {
        obs_t        e;
        logic        rst, rdy, z;
        logic [63:0] tag;
    } item_t;

    item_t       sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = 0;
    logic [1:0]  exp_hc = 2'b00;
    item_t       it;
    obs_t        got;

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t b(input logic [3:0] st);
        obs_t o;
        o = '0; o.st = st; o.hc = exp_hc; o.cnt = exp_cnt;
        return o;
    endfunction

    function automatic obs_t e_fetch(input logic rdy);
        obs_t o;
        o = b(4'd0); o.mem_rd = 1'b1; o.src_b = 2'b01; o.ir_we = rdy; o.pc_we = rdy;
        return o;
    endfunction
    function automatic obs_t e_decode();
        obs_t o;
        o = b(4'd1); o.src_b = 2'b11;
        return o;
    endfunction
    function automatic obs_t e_memadr();
        obs_t o;
        o = b(4'd2); o.src_a = 1'b1; o.src_b = 2'b10;
        return o;
    endfunction
    function automatic obs_t e_memrd();
        obs_t o;
        o = b(4'd3); o.mem_rd = 1'b1; o.iord = 1'b1;
        return o;
    endfunction
    function automatic obs_t e_memwb();
        obs_t o;
        o = b(4'd4); o.reg_we = 1'b1; o.mem_to_reg = 1'b1; o.done = 1'b1;
        return o;
    endfunction
    function automatic obs_t e_memwr(input logic rdy);
        obs_t o;
        o = b(4'd5); o.mem_wr = 1'b1; o.iord = 1'b1; o.done = rdy;
        return o;
    endfunction
    function automatic obs_t e_exec(input logic [2:0] op);
        obs_t o;
        o = b(4'd6); o.src_a = 1'b1; o.alu_op = op;
        return o;
    endfunction
    function automatic obs_t e_aluwb();
        obs_t o;
        o = b(4'd7); o.reg_we = 1'b1; o.reg_dst = 1'b1; o.done = 1'b1;
        return o;
    endfunction
    function automatic obs_t e_branch(input logic z);
        obs_t o;
        o = b(4'd8); o.src_a = 1'b1; o.alu_op = 3'b001; o.pc_src = 2'b01;
        o.pc_we = z; o.done = 1'b1;
        return o;
    endfunction
    function automatic obs_t e_jump();
        obs_t o;
        o = b(4'd9); o.pc_src = 2'b10; o.pc_we = 1'b1; o.done = 1'b1;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.pc_we = pc_we; o.ir_we = ir_we; o.reg_we = reg_we;
        o.mem_rd = mem_rd; o.mem_wr = mem_wr; o.iord = iord; o.src_a = alu_src_a;
        o.src_b = alu_src_b; o.alu_op = alu_op; o.pc_src = pc_src; o.reg_dst = reg_dst;
        o.mem_to_reg = mem_to_reg; o.done = instr_done; o.hc = halt_code; o.cnt = instret_cnt;
        return o;
    endfunction

    // Queue one cycle of stimulus with the observation it must produce
    task automatic push(input obs_t e, input logic r, input logic rdy, input logic z,
                        input logic [63:0] tag);
        item_t i;
        i.e = e; i.rst = r; i.rdy = rdy; i.z = z; i.tag = tag;
        sb.push_back(i);
        if (e.done) exp_cnt = exp_cnt + 1;
    endtask

    task automatic push_reset(input logic [3:0] st, input logic rdy);
        push(b(st), 1'b1, rdy, rnd(), "RESET");
        exp_cnt = 0;
        exp_hc  = 2'b00;
    endtask

    task automatic next_obs(output item_t i, output obs_t o);
        i = sb.pop_front();
        @(posedge clk);
        #1;
        rst = i.rst; mem_rdy = i.rdy; zero = i.z;
        @(negedge clk);
        o = sample();
    endtask

    task automatic set_ir(input logic [31:0] ir);
        opcode = ir[31:26];
        funct  = ir[5:0];
    endtask

    task automatic test_reset();
        push(b(4'd0), 1'b1, 1'b1, 1'b1, "RST0");
        push(b(4'd0), 1'b1, 1'b1, 1'b0, "RST1");
        while (sb.size() != 0) begin
            next_obs(it, got);
            checks++;
            if (got !== it.e) begin
                errors++;
                $display("FAIL reset %s: got=%h exp=%h", it.tag, got, it.e);
            end
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn [5];
        logic [2:0] op [5];
        fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        op = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        for (int k = 0; k < 5; k++) begin
            if (k == 0) set_ir(32'h00E2F820);
            else set_ir({6'h00, 20'h0, fn[k]});
            push(e_fetch(1'b1), 1'b0, 1'b1, rnd(), "FETCH");
            push(e_decode(), 1'b0, rnd(), rnd(), "DECODE");
            push(e_exec(op[k]), 1'b0, rnd(), rnd(), "EXEC");
            push(e_aluwb(), 1'b0, rnd(), rnd(), "ALUWB");
            while (sb.size() != 0) begin
                next_obs(it, got);
                checks++;
                if (got !== it.e) begin
                    errors++;
                    $display("FAIL rtype f=%h %s: got=%h exp=%h", fn[k], it.tag, got, it.e);
                end
            end
        end
    endtask

    task automatic test_lw();
        set_ir(32'h8C3F0000);
        push(e_fetch(1'b1), 1'b0, 1'b1, rnd(), "FETCH");
        push(e_decode(), 1'b0, rnd(), rnd(), "DECODE");
        push(e_memadr(), 1'b0, rnd(), rnd(), "MEMADR");
        push(e_memrd(), 1'b0, 1'b0, rnd(), "MEMRDW1");
        push(e_memrd(), 1'b0, 1'b0, rnd(), "MEMRDW2");
        push(e_memrd(), 1'b0, 1'b1, rnd(), "MEMRD");
        push(e_memwb(), 1'b0, rnd(), rnd(), "MEMWB");
        while (sb.size() != 0) begin
            next_obs(it, got);
            checks++;
            if (got !== it.e) begin
                errors++;
                $display("FAIL lw %s: got=%h exp=%h", it.tag, got, it.e);
            end
        end
    endtask

    task automatic test_sw_fetch_wait();
        set_ir(32'hAC3F0000);
        for (int k = 0; k < 7; k++) push(e_fetch(1'b0), 1'b0, 1'b0, rnd(), "FETCHW");
        push(e_fetch(1'b1), 1'b0, 1'b1, rnd(), "FETCH");
        push(e_decode(), 1'b0, rnd(), rnd(), "DECODE");
        push(e_memadr(), 1'b0, rnd(), rnd(), "MEMADR");
        push(e_memwr(1'b0), 1'b0, 1'b0, rnd(), "MEMWRW");
        push(e_memwr(1'b1), 1'b0, 1'b1, rnd(), "MEMWR");
        while (sb.size() != 0) begin
            next_obs(it, got);
            checks++;
            if (got !== it.e) begin
                errors++;
                $display("FAIL sw %s: got=%h exp=%h", it.tag, got, it.e);
            end
        end
    endtask

    task automatic test_beq_jump();
        set_ir(32'h10000003);
        for (int k = 1; k >= 0; k--) begin
            push(e_fetch(1'b1), 1'b0, 1'b1, rnd(), "FETCH");
            push(e_decode(), 1'b0, rnd(), rnd(), "DECODE");
            push(e_branch(1'(k)), 1'b0, rnd(), 1'(k), "BRANCH");
        end
        while (sb.size() != 0) begin
            next_obs(it, got);
            checks++;
            if (got !== it.e) begin
                errors++;
                $display("FAIL beq %s: got=%h exp=%h", it.tag, got, it.e);
            end
        end
        set_ir(32'h08000010);
        push(e_fetch(1'b1), 1'b0, 1'b1, rnd(), "FETCH");
        push(e_decode(), 1'b0, rnd(), rnd(), "DECODE");
        push(e_jump(), 1'b0, rnd(), rnd(), "JUMP");
        while (sb.size() != 0) begin
            next_obs(it, got);
            checks++;
            if (got !== it.e) begin
                errors++;
                $display("FAIL jump %s: got=%h exp=%h", it.tag, got, it.e);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] irs [2];
        irs = '{32'hFC000000, 32'h00000021};
        for (int k = 0; k < 2; k++) begin
            set_ir(irs[k]);
            push(e_fetch(1'b1), 1'b0, 1'b1, rnd(), "FETCH");
            push(e_decode(), 1'b0, rnd(), rnd(), "DECODE");
            exp_hc = 2'b01;
            for (int c = 0; c < 20; c++) push(b(4'd10), 1'b0, rnd(), rnd(), "HALT");
            push_reset(4'd10, 1'b1);
            while (sb.size() != 0) begin
                next_obs(it, got);
                checks++;
                if (got !== it.e) begin
                    errors++;
                    $display("FAIL illegal ir=%h %s: got=%h exp=%h", irs[k], it.tag, got, it.e);
                end
            end
            set_ir(32'h08000010);
            push(e_fetch(1'b1), 1'b0, 1'b1, rnd(), "FETCH");
            push(e_decode(), 1'b0, rnd(), rnd(), "DECODE");
            push(e_jump(), 1'b0, rnd(), rnd(), "JUMP");
            while (sb.size() != 0) begin
                next_obs(it, got);
                checks++;
                if (got !== it.e) begin
                    errors++;
                    $display("FAIL recover %s: got=%h exp=%h", it.tag, got, it.e);
                end
            end
        end
    endtask

    task automatic test_timeout();
        set_ir(32'h8C3F0000);
        push(e_fetch(1'b1), 1'b0, 1'b1, rnd(), "FETCH");
        push(e_decode(), 1'b0, rnd(), rnd(), "DECODE");
        push(e_memadr(), 1'b0, rnd(), rnd(), "MEMADR");
        push(e_memrd(), 1'b0, 1'b0, rnd(), "MEMRDW");
        push_reset(4'd3, 1'b0);
        for (int k = 0; k < 7; k++) push(e_fetch(1'b0), 1'b0, 1'b0, rnd(), "FETCHW");
        push(e_fetch(1'b0), 1'b0, 1'b0, rnd(), "FETCHW8");
        exp_hc = 2'b10;
        for (int k = 0; k < 3; k++) push(b(4'd10), 1'b0, rnd(), rnd(), "HALTTO");
        push_reset(4'd10, 1'b0);
        push(e_fetch(1'b1), 1'b0, 1'b1, rnd(), "FETCH");
        push(e_decode(), 1'b0, rnd(), rnd(), "DECODE");
        push(e_memadr(), 1'b0, rnd(), rnd(), "MEMADR");
        push(e_memrd(), 1'b0, 1'b1, rnd(), "MEMRD");
        push(e_memwb(), 1'b0, rnd(), rnd(), "MEMWB");
        while (sb.size() != 0) begin
            next_obs(it, got);
            checks++;
            if (got !== it.e) begin
                errors++;
                $display("FAIL timeout %s: got=%h exp=%h", it.tag, got, it.e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; mem_rdy = 1'b0; zero = 1'b0; opcode = 6'h00; funct = 6'h00;
        repeat (2) @(posedge clk);
        test_reset();
        test_rtype();
        test_lw();
        test_sw_fetch_wait();
        test_beq_jump();
        test_illegal();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
